// File: rtl/memory_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage_pkg                                                     |
// | Opcode constants, load/store decode enums and helpers for M stage.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_stage_pkg;

  localparam logic [5:0] c_op_sw  = 6'b101011;
  localparam logic [5:0] c_op_sh  = 6'b101001;
  localparam logic [5:0] c_op_sb  = 6'b101000;
  localparam logic [5:0] c_op_lw  = 6'b100011;
  localparam logic [5:0] c_op_lh  = 6'b100001;
  localparam logic [5:0] c_op_lhu = 6'b100101;
  localparam logic [5:0] c_op_lb  = 6'b100000;
  localparam logic [5:0] c_op_lbu = 6'b100100;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_WORD,
    LD_HALF_S,
    LD_HALF_U,
    LD_BYTE_S,
    LD_BYTE_U
  } load_ext_e;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_WORD,
    ST_HALF,
    ST_BYTE
  } store_size_e;

  function automatic load_ext_e decode_load(input logic [5:0] op);
    case (op)
      c_op_lw:  return LD_WORD;
      c_op_lh:  return LD_HALF_S;
      c_op_lhu: return LD_HALF_U;
      c_op_lb:  return LD_BYTE_S;
      c_op_lbu: return LD_BYTE_U;
      default:  return LD_NONE;
    endcase
  endfunction

  function automatic store_size_e decode_store(input logic [5:0] op);
    case (op)
      c_op_sw: return ST_WORD;
      c_op_sh: return ST_HALF;
      c_op_sb: return ST_BYTE;
      default: return ST_NONE;
    endcase
  endfunction

  // Low address bits pick the lane; misaligned bits below the access size are ignored.
  function automatic logic [31:0] extend_load(input load_ext_e kind,
                                              input logic [31:0] word,
                                              input logic [1:0] off);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (kind)
      LD_WORD:   return word;
      LD_HALF_S: return {{16{half_v[15]}}, half_v};
      LD_HALF_U: return {16'd0, half_v};
      LD_BYTE_S: return {{24{byte_v[7]}}, byte_v};
      LD_BYTE_U: return {24'd0, byte_v};
      default:   return word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage_if                                                      |
// | E->M inputs, W forwarding inputs and M-stage outputs bundle.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface memory_stage_if;
  logic [31:0] InstrE;
  logic [4:0]  A3EM;
  logic [31:0] WDEM;
  logic [31:0] ResEM;
  logic [31:0] RD2EM;
  logic [4:0]  A3W;
  logic [31:0] WDW;
  logic [31:0] InstrM;
  logic [4:0]  A3M;
  logic [31:0] WDM;
  logic        LoadM;
  logic [4:0]  A3MW;
  logic [31:0] WDMW;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;

  modport master (
    output InstrE, A3EM, WDEM, ResEM, RD2EM, A3W, WDW,
    input  InstrM, A3M, WDM, LoadM, A3MW, WDMW, dm_we, dm_addr, dm_wdata
  );

  modport slave (
    input  InstrE, A3EM, WDEM, ResEM, RD2EM, A3W, WDW,
    output InstrM, A3M, WDM, LoadM, A3MW, WDMW, dm_we, dm_addr, dm_wdata
  );
endinterface
`default_nettype wire

// File: rtl/memory_stage_dm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_bank                                                              |
// | Word-indexed data memory: byte-enable sync write, async read/clear.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dm_bank #(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [3:0]       i_we,
  input  wire logic [DM_AW-1:0] i_idx,
  input  wire logic [31:0]      i_wdata,
  output logic      [31:0]      o_rdata
);

  logic [31:0] w_words [DM_WORDS];

  // One register per word so the whole array can be cleared asynchronously.
  for (genvar gw = 0; gw < DM_WORDS; gw++) begin : g_word
    logic [31:0] r_word;
    logic        w_sel;

    assign w_sel = (i_idx == gw[DM_AW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word <= '0;
      end else if (w_sel) begin
        for (int b = 0; b < 4; b++) begin
          if (i_we[b]) r_word[8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end

    assign w_words[gw] = r_word;
  end

  assign o_rdata = w_words[i_idx];

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage                                                         |
// | MIPS M stage: E/M register, byte/half/word stores, extended loads.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int DM_WORDS = 4096,
  parameter int DM_AW    = 12
) (
  input wire logic         clk,
  input wire logic         reset,
  memory_stage_if.slave    bus
);

  logic [31:0] r_instr_m;
  logic [4:0]  r_a3_m;
  logic [31:0] r_wd_m;
  logic [31:0] r_res_m;
  logic [31:0] r_rd2_m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_m <= '0;
      r_a3_m    <= '0;
      r_wd_m    <= '0;
      r_res_m   <= '0;
      r_rd2_m   <= '0;
    end else begin
      r_instr_m <= bus.InstrE;
      r_a3_m    <= bus.A3EM;
      r_wd_m    <= bus.WDEM;
      r_res_m   <= bus.ResEM;
      r_rd2_m   <= bus.RD2EM;
    end
  end

  logic [31:0]      w_sd;
  store_size_e      w_st;
  load_ext_e        w_ld;
  logic [DM_AW-1:0] w_idx;
  logic [3:0]       w_we;
  logic [31:0]      w_wdata;
  logic [31:0]      w_rdata;
  logic [31:0]      w_ld_data;

  // W result wins over the stale E-stage rt value when W writes the store's rt.
  assign w_sd  = ((bus.A3W != 5'd0) && (bus.A3W == r_instr_m[20:16])) ? bus.WDW : r_rd2_m;
  assign w_st  = decode_store(r_instr_m[31:26]);
  assign w_ld  = decode_load(r_instr_m[31:26]);
  assign w_idx = r_res_m[DM_AW+1:2];

  always_comb begin
    w_we    = 4'b0000;
    w_wdata = w_sd;
    case (w_st)
      ST_WORD: w_we = 4'b1111;
      ST_HALF: begin
        w_we    = r_res_m[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_sd[15:0]}};
      end
      ST_BYTE: begin
        w_we    = 4'b0001 << r_res_m[1:0];
        w_wdata = {4{w_sd[7:0]}};
      end
      default: w_we = 4'b0000;
    endcase
  end

  dm_bank #(
    .DM_WORDS (DM_WORDS),
    .DM_AW    (DM_AW)
  ) u_dm_bank (
    .clk     (clk),
    .rst_n   (reset),
    .i_we    (w_we),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_ld_data = extend_load(w_ld, w_rdata, r_res_m[1:0]);

  assign bus.InstrM   = r_instr_m;
  assign bus.A3M      = r_a3_m;
  assign bus.WDM      = r_wd_m;
  assign bus.LoadM    = (w_ld != LD_NONE);
  assign bus.A3MW     = r_a3_m;
  assign bus.WDMW     = (w_ld != LD_NONE) ? w_ld_data : r_wd_m;
  assign bus.dm_we    = w_we;
  assign bus.dm_addr  = r_res_m;
  assign bus.dm_wdata = w_wdata;

endmodule
`default_nettype wire
